// File: rtl/program_counter_unit_if.sv
// Control/status bundle between the instruction-fetch controller and the
// program counter unit. The master drives redirect requests and observes the
// PC and return-address-stack status; the slave is the PC unit itself.
interface program_counter_unit_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             pcWrite__i;
  logic             branch__i;
  logic [WIDTH-1:0] branchTarget__i;
  logic             jump__i;
  logic             call__i;
  logic [WIDTH-1:0] jumpTarget__i;
  logic             return__i;
  logic             exception__i;
  logic [WIDTH-1:0] address__o;
  logic [WIDTH-1:0] epc__o;
  logic [CNT_W-1:0] rasCount__o;
  logic             rasOverflow__o;
  logic             rasUnderflow__o;

  modport master (
    output pcWrite__i, branch__i, branchTarget__i, jump__i, call__i,
           jumpTarget__i, return__i, exception__i,
    input  address__o, epc__o, rasCount__o, rasOverflow__o, rasUnderflow__o
  );

  modport slave (
    input  pcWrite__i, branch__i, branchTarget__i, jump__i, call__i,
           jumpTarget__i, return__i, exception__i,
    output address__o, epc__o, rasCount__o, rasOverflow__o, rasUnderflow__o
  );
endinterface

// File: rtl/program_counter_unit.sv
// Program counter with prioritised redirect (exception > branch > return >
// jump/call > sequential) and a circular return-address stack. The PC, EPC,
// stack count and status pulses are all registered; the selected next PC
// appears on address__o one cycle after the request is sampled.
module program_counter_unit #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                  clock__i,
  input  logic                  reset__i,
  program_counter_unit_if.slave pc_bus
);

  localparam int               PTR_W      = $clog2(RAS_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] epc_reg, epc_next;
  // ptr_reg is the slot the next push writes; the top of stack sits one below.
  // When the stack is full that slot holds the oldest entry, so a push there
  // overwrites it and the stack behaves as a circular buffer.
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;

  logic             push_en;
  logic [WIDTH-1:0] seq_pc;
  logic [PTR_W-1:0] top_ptr;
  logic [WIDTH-1:0] ras_top;
  logic [RAS_DEPTH-1:0] ras_wr_en;
  logic [WIDTH-1:0] ras_mem_reg [RAS_DEPTH];

  assign seq_pc  = pc_reg + STEP_W;
  assign top_ptr = ptr_reg - PTR_W'(1);
  // Pops need the top entry in the same cycle, so the stack is read
  // asynchronously; it is small enough to live in registers.
  assign ras_top = ras_mem_reg[top_ptr];

  // Per-entry write strobes; a reset in the same cycle discards the push.
  genvar gi;
  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras_we
      assign ras_wr_en[gi] = push_en & ~reset__i & (ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Next-state selection in redirect priority order.
  always_comb begin
    pc_next  = pc_reg;
    epc_next = epc_reg;
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    push_en  = 1'b0;

    if (pc_bus.exception__i) begin
      // Exceptions ignore the stall and never touch the stack.
      pc_next  = EXC_VECTOR;
      epc_next = pc_reg;
    end else if (pc_bus.pcWrite__i) begin
      if (pc_bus.branch__i) begin
        pc_next = pc_bus.branchTarget__i;
      end else if (pc_bus.return__i) begin
        if (cnt_reg != '0) begin
          pc_next  = ras_top;
          ptr_next = top_ptr;
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          // Empty stack: fall through sequentially and flag it.
          pc_next  = seq_pc;
          unf_next = 1'b1;
        end
      end else if (pc_bus.jump__i) begin
        pc_next = pc_bus.jumpTarget__i;
        if (pc_bus.call__i) begin
          push_en  = 1'b1;
          ptr_next = ptr_reg + PTR_W'(1);
          if (cnt_reg == FULL_COUNT) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end else begin
        pc_next = seq_pc;
      end
    end
  end

  // PC, EPC, stack pointer/count and status pulse registers.
  always_ff @(posedge clock__i) begin
    if (reset__i) begin
      pc_reg  <= RESET_VECTOR;
      epc_reg <= '0;
      ptr_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      epc_reg <= epc_next;
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  // Return-address storage; contents are left alone by reset because a zero
  // count makes every entry unreachable.
  always_ff @(posedge clock__i) begin
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (ras_wr_en[i]) begin
        ras_mem_reg[i] <= seq_pc;
      end
    end
  end

  assign pc_bus.address__o      = pc_reg;
  assign pc_bus.epc__o          = epc_reg;
  assign pc_bus.rasCount__o     = cnt_reg;
  assign pc_bus.rasOverflow__o  = ovf_reg;
  assign pc_bus.rasUnderflow__o = unf_reg;

endmodule

// File: tb/tb_program_counter_unit.sv
// Bench for program_counter_unit: a directed vector table walking through
// reset, call/return, stack overflow/underflow, stalls, priority and wrap,
// followed by randomized traffic compared against a queue-based model.
module tb_program_counter_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] EXC   = 32'h80;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  program_counter_unit_if #(.WIDTH(32), .RAS_DEPTH(DEPTH)) pc_if ();

  program_counter_unit #(
    .WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock__i(clk),
    .reset__i(rst),
    .pc_bus(pc_if)
  );

  // ctl bits: {rst, pcw, exc, br, ret, jmp, call}; pulses: {ovf, unf}
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic [2:0]  exp_cnt;
    logic [1:0]  exp_pulse;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf;

  task automatic add(input logic [6:0] ctl, input logic [31:0] bt, input logic [31:0] jt,
                     input logic [31:0] pc, input logic [31:0] epc, input logic [2:0] cnt,
                     input logic [1:0] pulse);
    vec_t v;
    v.ctl = ctl; v.bt = bt; v.jt = jt; v.exp_pc = pc; v.exp_epc = epc;
    v.exp_cnt = cnt; v.exp_pulse = pulse;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1ns after the edge.
  task automatic drive(input logic [6:0] ctl, input logic [31:0] bt, input logic [31:0] jt);
    @(negedge clk);
    rst                   = ctl[6];
    pc_if.pcWrite__i      = ctl[5];
    pc_if.exception__i    = ctl[4];
    pc_if.branch__i       = ctl[3];
    pc_if.return__i       = ctl[2];
    pc_if.jump__i         = ctl[1];
    pc_if.call__i         = ctl[0];
    pc_if.branchTarget__i = bt;
    pc_if.jumpTarget__i   = jt;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: the architectural rules written directly, with the
  // return-address stack as a bounded queue (oldest at the front).
  task automatic model_step(input logic [6:0] ctl, input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] link;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (ctl[6]) begin
      m_pc = 32'h0; m_epc = 32'h0; m_ras.delete();
    end else if (ctl[4]) begin
      m_epc = m_pc; m_pc = EXC;
    end else if (ctl[5]) begin
      if (ctl[3]) m_pc = bt;
      else if (ctl[2]) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = m_pc + 32'd4; m_unf = 1'b1; end
      end else if (ctl[1]) begin
        if (ctl[0]) begin
          link = m_pc + 32'd4;
          m_ras.push_back(link);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
        end
        m_pc = jt;
      end else m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    pc_if.pcWrite__i = 0; pc_if.exception__i = 0; pc_if.branch__i = 0;
    pc_if.return__i = 0; pc_if.jump__i = 0; pc_if.call__i = 0;
    pc_if.branchTarget__i = 0; pc_if.jumpTarget__i = 0;

    // Sequential fetch after reset
    add(7'b1000000, 0, 0, 32'h0,   32'h0, 3'd0, 2'b00);
    add(7'b0100000, 0, 0, 32'h4,   32'h0, 3'd0, 2'b00);
    add(7'b0100000, 0, 0, 32'h8,   32'h0, 3'd0, 2'b00);
    add(7'b0100000, 0, 0, 32'hC,   32'h0, 3'd0, 2'b00);
    add(7'b0100000, 0, 0, 32'h10,  32'h0, 3'd0, 2'b00);
    // Call from 0x10, two steps, return
    add(7'b0100011, 0, 32'h100, 32'h100, 32'h0, 3'd1, 2'b00);
    add(7'b0100000, 0, 0, 32'h104, 32'h0, 3'd1, 2'b00);
    add(7'b0100000, 0, 0, 32'h108, 32'h0, 3'd1, 2'b00);
    add(7'b0100100, 0, 0, 32'h14,  32'h0, 3'd0, 2'b00);
    // Five nested calls overflow a 4-deep stack, then unwind and underflow
    add(7'b1000000, 0, 0, 32'h0,   32'h0, 3'd0, 2'b00);
    add(7'b0100011, 0, 32'h20, 32'h20, 32'h0, 3'd1, 2'b00);
    add(7'b0100011, 0, 32'h40, 32'h40, 32'h0, 3'd2, 2'b00);
    add(7'b0100011, 0, 32'h60, 32'h60, 32'h0, 3'd3, 2'b00);
    add(7'b0100011, 0, 32'h80, 32'h80, 32'h0, 3'd4, 2'b00);
    add(7'b0100011, 0, 32'hA0, 32'hA0, 32'h0, 3'd4, 2'b10);
    add(7'b0100100, 0, 0, 32'h84,  32'h0, 3'd3, 2'b00);
    add(7'b0100100, 0, 0, 32'h64,  32'h0, 3'd2, 2'b00);
    add(7'b0100100, 0, 0, 32'h44,  32'h0, 3'd1, 2'b00);
    add(7'b0100100, 0, 0, 32'h24,  32'h0, 3'd0, 2'b00);
    add(7'b0100100, 0, 0, 32'h28,  32'h0, 3'd0, 2'b01);
    add(7'b0100000, 0, 0, 32'h2C,  32'h0, 3'd0, 2'b00);
    add(7'b0100000, 0, 0, 32'h30,  32'h0, 3'd0, 2'b00);
    // Stall blocks a branch but not an exception
    add(7'b0001000, 32'h500, 0, 32'h30, 32'h0, 3'd0, 2'b00);
    add(7'b0010000, 0, 0, 32'h80,  32'h30, 3'd0, 2'b00);
    // Priority: everything at once, then branch over return
    add(7'b0100011, 0, 32'h200, 32'h200, 32'h30, 3'd1, 2'b00);
    add(7'b0111111, 32'h300, 32'h400, 32'h80, 32'h200, 3'd1, 2'b00);
    add(7'b0101100, 32'h300, 0, 32'h300, 32'h200, 3'd1, 2'b00);
    add(7'b0100100, 0, 0, 32'h84,  32'h200, 3'd0, 2'b00);
    // Address wrap, reset discarding a call
    add(7'b0100010, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h200, 3'd0, 2'b00);
    add(7'b0100000, 0, 0, 32'h0,   32'h200, 3'd0, 2'b00);
    add(7'b0100011, 0, 32'h400, 32'h400, 32'h200, 3'd1, 2'b00);
    add(7'b1100011, 0, 32'h500, 32'h0, 32'h0, 3'd0, 2'b00);
    add(7'b0100100, 0, 0, 32'h4,   32'h0, 3'd0, 2'b01);
    // Stalled return, then call without jump
    add(7'b0000100, 0, 0, 32'h4,   32'h0, 3'd0, 2'b00);
    add(7'b0100001, 0, 32'h700, 32'h8, 32'h0, 3'd0, 2'b00);

    foreach (vecs[i]) begin
      drive(vecs[i].ctl, vecs[i].bt, vecs[i].jt);
      $display("vec %0d ctl=%b pc=%h epc=%h cnt=%0d ovf=%b unf=%b", i, vecs[i].ctl,
               pc_if.address__o, pc_if.epc__o, pc_if.rasCount__o,
               pc_if.rasOverflow__o, pc_if.rasUnderflow__o);
      check($sformatf("vec%0d_pc", i), pc_if.address__o, vecs[i].exp_pc);
      check($sformatf("vec%0d_epc", i), pc_if.epc__o, vecs[i].exp_epc);
      check($sformatf("vec%0d_cnt", i), 32'(pc_if.rasCount__o), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_ovf", i), 32'(pc_if.rasOverflow__o), 32'(vecs[i].exp_pulse[1]));
      check($sformatf("vec%0d_unf", i), 32'(pc_if.rasUnderflow__o), 32'(vecs[i].exp_pulse[0]));
    end

    // Randomized traffic against the model, starting from reset
    model_step(7'b1000000, 0, 0);
    drive(7'b1000000, 0, 0);
    for (int n = 0; n < 400; n++) begin
      logic [6:0]  ctl;
      logic [31:0] bt, jt;
      ctl[6] = ($urandom_range(0, 63) == 0);
      ctl[5] = ($urandom_range(0, 7) != 0);
      ctl[4] = ($urandom_range(0, 15) == 0);
      ctl[3] = ($urandom_range(0, 7) == 0);
      ctl[2] = ($urandom_range(0, 3) == 0);
      ctl[1] = ($urandom_range(0, 2) == 0);
      ctl[0] = ($urandom_range(0, 1) == 0);
      bt = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      jt = ($urandom_range(0, 1) == 0) ? {$urandom_range(0, 4095), 2'b00} : $urandom;
      model_step(ctl, bt, jt);
      drive(ctl, bt, jt);
      $display("rnd %0d ctl=%b pc=%h epc=%h cnt=%0d ovf=%b unf=%b", n, ctl,
               pc_if.address__o, pc_if.epc__o, pc_if.rasCount__o,
               pc_if.rasOverflow__o, pc_if.rasUnderflow__o);
      check("rnd_pc", pc_if.address__o, m_pc);
      check("rnd_epc", pc_if.epc__o, m_epc);
      check("rnd_cnt", 32'(pc_if.rasCount__o), m_ras.size());
      check("rnd_ovf", 32'(pc_if.rasOverflow__o), 32'(m_ovf));
      check("rnd_unf", 32'(pc_if.rasUnderflow__o), 32'(m_unf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
